syndrome_round_loader: RTL and testbench
========================================

Name: syndrome_round_loader

Overview:
- Upstream stage of the left decoder-with-stage-controller wrapper.
- Accepts one measurement round of error syndromes as a stream of fixed-width words over valid/ready.
- Assembles the words into the PU_COUNT-bit is_error_syndromes vector and pulses new_round_start.
- Holds the vector stable until the stage controller reports completion.
- Ping-pong buffered, so the next round loads while the current round decodes.

Parameters:
- CODE_DISTANCE_X, 5, X distance; must match the downstream decoder.
- CODE_DISTANCE_Z, 4, Z distance; must match the downstream decoder.
- WORD_WIDTH, 32, input stream word width in bits.
- ROUND_ID_WIDTH, 16, width of the issued-round counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk; low = reset.
- s_data  in  WORD_WIDTH  syndrome word.
- s_valid  in  1  word valid.
- s_last  in  1  marks the final word of a round.
- s_ready  out  1  word accepted when s_valid & s_ready.
- is_error_syndromes  out  PU_COUNT  syndrome vector to the decoder.
- new_round_start  out  1  one-cycle start pulse.
- result_valid  in  1  level from the stage controller.
- deadlock  in  1  level from the stage controller.
- busy  out  1  a round is issued and not yet complete.
- round_done  out  1  one-cycle pulse when a round completes.
- round_aborted  out  1  one-cycle pulse, coincident with round_done, when completion was caused by deadlock.
- round_id  out  ROUND_ID_WIDTH  count of rounds issued.
- frame_error  out  1  sticky framing-error flag.

Behaviour:
- Derived values:
  - MEASUREMENT_ROUNDS = max(X, Z).
  - PU_COUNT = X*Z*MEASUREMENT_ROUNDS (100 at defaults).
  - WORDS = ceil(PU_COUNT/WORD_WIDTH) (4 at defaults).
- Word mapping: word k fills bits [k*WORD_WIDTH +: WORD_WIDTH]. Bits at or above PU_COUNT in the last word are discarded. Word 0 carries PU 0.
- Framing:
  - s_last must coincide with word WORDS-1.
  - If s_last arrives early: frame_error is set and the partial buffer is dropped; the next word is word 0.
  - If word WORDS-1 arrives without s_last: frame_error is set, the buffer is dropped, and further words are accepted and dropped up to and including the next s_last.
  - frame_error clears only on reset.
- Buffers: two banks, FILL and HOLD.
  - HOLD drives is_error_syndromes; it is stable from the new_round_start cycle until the done cycle.
  - A completed FILL bank is "pending".
- Issue FSM states: IDLE, START, WAIT.
  - IDLE → START when a bank is pending. Banks swap and new_round_start=1 in that same cycle (START lasts exactly one cycle).
  - START → WAIT.
  - In WAIT, done = (result_valid rising edge vs registered prev) | deadlock.
  - On done: round_done=1 (and round_aborted=deadlock), then → IDLE.
  - A pending bank is therefore issued at the earliest one cycle after round_done.
- Latency: if idle, the last word accepted at cycle t gives new_round_start at t+1.
- Ready:
  - s_ready=0 while a bank is pending and the FSM is not IDLE (both banks occupied).
  - Otherwise s_ready=1, including during drop mode.
- Simultaneous events:
  - A completing word and done in the same cycle: the completed bank becomes pending and is issued from IDLE next cycle.
  - result_valid already high at issue does not count as done; a rising edge is required.
- round_id increments on every new_round_start and wraps modulo 2^ROUND_ID_WIDTH.
- Reset (including mid-round): all outputs 0, FSM IDLE, word index 0, no pending bank, banks cleared, drop mode off.

Optional Feature:
- Macro: SYNDROME_LOADER_STATS_EN.
- Defined:
  - Adds outputs stat_stall_cycles[31:0] (cycles with s_valid & ~s_ready) and stat_decode_cycles[31:0] (cycles of the last completed round, from START to done inclusive).
  - Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package helios_loader_pkg holds:
  - the MAX-based MEASUREMENT_ROUNDS, PU_COUNT and WORDS calculation functions;
  - the FSM state enum (IDLE, START, WAIT).
- One sub-module, syndrome_word_assembler:
  - owns the word index, the framing check, drop mode and a single bank write;
  - outputs bank_complete and frame_err pulses.
- The top level owns bank swap, the FSM and the counters.

Test Plan:
- Defaults; 4 words 0xFFFFFFFF with s_last on word 3 → new_round_start the cycle after word 3; is_error_syndromes = 100 ones; upper 28 bits of word 3 discarded; round_id=1.
- Round A issued; stream round B during WAIT; stream round C → s_ready low after B completes. result_valid rises → round_done; B issued the next cycle; s_ready returns high.
- s_last on word 1 → frame_error=1, no new_round_start; the next clean 4-word round issues normally.
- Word 3 without s_last, then 2 extra words, the second carrying s_last → all dropped, frame_error=1, no issue; the next round is correct.
- In WAIT assert deadlock for 1 cycle → round_done=1 and round_aborted=1 in the same cycle; busy falls.
- Reset low for 1 cycle mid-WAIT with a pending bank → all outputs 0, pending bank discarded, round_id=0.

Source files
------------

// File: rtl/helios_loader_pkg.sv
// Shared sizing helpers and issue-FSM state encoding for the syndrome round loader.
package helios_loader_pkg;

  typedef logic [1:0] loader_state_t;

  localparam loader_state_t StIdle  = 2'd0;
  localparam loader_state_t StStart = 2'd1;
  localparam loader_state_t StWait  = 2'd2;

  function automatic int unsigned measurement_rounds(input int unsigned dx,
                                                     input int unsigned dz);
    return (dx > dz) ? dx : dz;
  endfunction

  function automatic int unsigned pu_count(input int unsigned dx, input int unsigned dz);
    return dx * dz * measurement_rounds(dx, dz);
  endfunction

  function automatic int unsigned word_count(input int unsigned dx, input int unsigned dz,
                                             input int unsigned width);
    return (pu_count(dx, dz) + width - 1) / width;
  endfunction

endpackage

// File: rtl/syndrome_word_assembler.sv
// Tracks the word index of the round being streamed in, checks framing against s_last,
// and issues one bank write per accepted word.
module syndrome_word_assembler #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned WORDS      = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  word_accept,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  wr_en,
  output logic [IDX_W-1:0]      wr_idx,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  bank_complete,
  output logic                  frame_err
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             drop_q, drop_d;
  logic             is_final;

  assign is_final = (idx_q == IDX_W'(WORDS - 1));
  assign wr_idx   = idx_q;
  assign wr_data  = s_data;

  always_comb begin
    idx_d         = idx_q;
    drop_d        = drop_q;
    wr_en         = 1'b0;
    bank_complete = 1'b0;
    frame_err     = 1'b0;
    if (word_accept) begin
      if (drop_q) begin
        // Swallow everything up to and including the next s_last.
        if (s_last) begin
          drop_d = 1'b0;
          idx_d  = '0;
        end
      end else if (s_last && !is_final) begin
        frame_err = 1'b1;
        idx_d     = '0;
      end else if (is_final && !s_last) begin
        frame_err = 1'b1;
        drop_d    = 1'b1;
        idx_d     = '0;
      end else begin
        wr_en = 1'b1;
        if (is_final) begin
          bank_complete = 1'b1;
          idx_d         = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: rtl/syndrome_round_loader.sv
// Ping-pong syndrome round loader feeding the decoder stage controller.
// Optional statistics counters are enabled with SYNDROME_LOADER_STATS_EN.
module syndrome_round_loader
  import helios_loader_pkg::*;
#(
  parameter int unsigned CODE_DISTANCE_X = 5,
  parameter int unsigned CODE_DISTANCE_Z = 4,
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned ROUND_ID_WIDTH  = 16
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [WORD_WIDTH-1:0]                                 s_data,
  input  logic                                                  s_valid,
  input  logic                                                  s_last,
  output logic                                                  s_ready,
  output logic [pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z)-1:0] is_error_syndromes,
  output logic                                                  new_round_start,
  input  logic                                                  result_valid,
  input  logic                                                  deadlock,
  output logic                                                  busy,
  output logic                                                  round_done,
  output logic                                                  round_aborted,
  output logic [ROUND_ID_WIDTH-1:0]                             round_id,
`ifdef SYNDROME_LOADER_STATS_EN
  output logic [31:0]                                           stat_stall_cycles,
  output logic [31:0]                                           stat_decode_cycles,
`endif
  output logic                                                  frame_error
);

  localparam int unsigned PuCount = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z);
  localparam int unsigned Words   = word_count(CODE_DISTANCE_X, CODE_DISTANCE_Z, WORD_WIDTH);
  localparam int unsigned IdxW    = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned WideW   = Words * WORD_WIDTH;
  localparam logic [WideW-1:0] WordOnes = WideW'({WORD_WIDTH{1'b1}});

  loader_state_t           state_q, state_d;
  logic                    pending_q, fill_sel_q, disp_sel_q, rv_prev_q, frame_error_q;
  logic [PuCount-1:0]      bank_q [2];
  logic [ROUND_ID_WIDTH-1:0] round_id_q;

  logic                    word_accept, wr_en, bank_complete, frame_err;
  logic [IdxW-1:0]         wr_idx;
  logic [WORD_WIDTH-1:0]   wr_data;
  logic [PuCount-1:0]      wr_mask, wr_bits;
  logic                    issue, done;

  syndrome_word_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (Words),
    .IDX_W      (IdxW)
  ) u_assembler (
    .clk           (clk),
    .reset         (reset),
    .word_accept   (word_accept),
    .s_data        (s_data),
    .s_last        (s_last),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .bank_complete (bank_complete),
    .frame_err     (frame_err)
  );

  // Both banks hold a round only when one is pending while another is issued.
  assign s_ready     = reset & ~(pending_q & (state_q != StIdle));
  assign word_accept = s_valid & s_ready;

  assign issue = reset & (state_q == StIdle) & pending_q;
  assign done  = reset & (state_q == StWait) & ((result_valid & ~rv_prev_q) | deadlock);

  assign new_round_start    = issue;
  assign round_done         = done;
  assign round_aborted      = done & deadlock;
  assign busy               = (state_q != StIdle);
  assign round_id           = round_id_q;
  assign frame_error        = frame_error_q;
  // The pending bank is displayed already in the issue cycle.
  assign is_error_syndromes = bank_q[issue ? ~fill_sel_q : disp_sel_q];

  assign wr_mask = PuCount'(WordOnes << (int'(wr_idx) * WORD_WIDTH));
  assign wr_bits = PuCount'({Words{wr_data}});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (issue) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      fill_sel_q    <= 1'b0;
      disp_sel_q    <= 1'b0;
      rv_prev_q     <= 1'b0;
      frame_error_q <= 1'b0;
      round_id_q    <= '0;
      bank_q[0]     <= '0;
      bank_q[1]     <= '0;
    end else begin
      state_q   <= state_d;
      rv_prev_q <= result_valid;
      if (frame_err) frame_error_q <= 1'b1;
      if (bank_complete) begin
        pending_q  <= 1'b1;
        fill_sel_q <= ~fill_sel_q;
      end else if (issue) begin
        pending_q <= 1'b0;
      end
      if (issue) begin
        disp_sel_q <= ~fill_sel_q;
        round_id_q <= round_id_q + 1'b1;
      end
      if (wr_en) bank_q[fill_sel_q] <= (bank_q[fill_sel_q] & ~wr_mask) | (wr_bits & wr_mask);
    end
  end

`ifdef SYNDROME_LOADER_STATS_EN
  logic [31:0] stall_q, decode_q, cur_q;

  assign stat_stall_cycles  = stall_q;
  assign stat_decode_cycles = decode_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q  <= '0;
      decode_q <= '0;
      cur_q    <= '0;
    end else begin
      if (s_valid && !s_ready && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (issue) begin
        cur_q <= '0;
      end else if ((state_q != StIdle) && (cur_q != '1)) begin
        cur_q <= cur_q + 1'b1;
      end
      // cur_q counts cycles before the current one, so the done cycle is added here.
      if (done) decode_q <= (cur_q == '1) ? cur_q : cur_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_syndrome_round_loader.sv
// Scoreboard bench for syndrome_round_loader at default parameters.
module tb_syndrome_round_loader;

  localparam int PU = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic [PU-1:0] is_error_syndromes;
  logic          new_round_start;
  logic          result_valid = 1'b0;
  logic          deadlock = 1'b0;
  logic          busy, round_done, round_aborted, frame_error;
  logic [15:0]   round_id;

  int checks = 0;
  int errors = 0;
  int exp_id = 0;

  logic [PU-1:0] exp_vec_q [$];
  int            exp_id_q  [$];
  logic          exp_abort_q [$];

  syndrome_round_loader dut (
    .clk                (clk),
    .reset              (reset),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_last             (s_last),
    .s_ready            (s_ready),
    .is_error_syndromes (is_error_syndromes),
    .new_round_start    (new_round_start),
    .result_valid       (result_valid),
    .deadlock           (deadlock),
    .busy               (busy),
    .round_done         (round_done),
    .round_aborted      (round_aborted),
    .round_id           (round_id),
    .frame_error        (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int   n = 0;
    logic acc;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", acc, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Expected vector is the words concatenated with word 0 at the LSB, truncated to PU bits.
  task automatic push_round(input logic [31:0] w0, w1, w2, w3);
    logic [127:0] full;
    full = {w3, w2, w1, w0};
    exp_id++;
    exp_vec_q.push_back(full[PU-1:0]);
    exp_id_q.push_back(exp_id);
  endtask

  task automatic send_round(input logic [31:0] w0, w1, w2, w3);
    send(w0, 1'b0);
    send(w1, 1'b0);
    send(w2, 1'b0);
    send(w3, 1'b1);
    push_round(w0, w1, w2, w3);
  endtask

  task automatic finish_round(input logic abort);
    exp_abort_q.push_back(abort);
    if (abort) deadlock = 1'b1;
    else result_valid = 1'b1;
    @(posedge clk);
    #1;
    deadlock     = 1'b0;
    result_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_vec_q.delete();
    exp_id_q.delete();
    exp_abort_q.delete();
    exp_id = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares every start pulse and every done pulse against the queues.
  initial begin
    logic [PU-1:0] ev;
    int            eid;
    forever begin
      @(negedge clk);
      if (round_done) begin
        if (exp_abort_q.size() == 0) chk("unexpected_done", round_done, 0);
        else chk("round_aborted", round_aborted, exp_abort_q.pop_front());
      end
      if (new_round_start) begin
        if (exp_vec_q.size() == 0) begin
          chk("unexpected_start", new_round_start, 0);
        end else begin
          ev  = exp_vec_q.pop_front();
          eid = exp_id_q.pop_front();
          chk("syndromes", is_error_syndromes, ev);
          @(negedge clk);
          chk("round_id", round_id, eid);
          chk("busy_after_start", busy, 1);
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_syndromes", is_error_syndromes, 0);
    chk("rst_start", new_round_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round_id", round_id, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // All-ones round: start pulse one cycle after the last word
    send_round(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("latency_start", new_round_start, 1);
    chk("ones_vector", is_error_syndromes, {PU{1'b1}});
    cycles(2);
    finish_round(1'b0);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    cycles(1);

    // Round A in WAIT, B loads behind it, C stalls until A completes
    send_round(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hA5A5_A5A5);
    cycles(2);
    send_round(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0001, 32'h8000_000C);
    s_data  = 32'h1111_1111;
    s_valid = 1'b1;
    s_last  = 1'b0;
    @(negedge clk);
    chk("stall_ready", s_ready, 0);
    @(posedge clk);
    #1;
    exp_abort_q.push_back(1'b0);
    result_valid = 1'b1;
    @(negedge clk);
    chk("stall_ready_done", s_ready, 0);
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    @(negedge clk);
    chk("b_issue", new_round_start, 1);
    chk("ready_back", s_ready, 1);
    @(posedge clk);
    #1;
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b0);
    send(32'h4444_4444, 1'b1);
    push_round(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    finish_round(1'b0);
    cycles(3);
    finish_round(1'b0);
    cycles(2);

    // Early s_last
    send(32'h5555_5555, 1'b0);
    send(32'h6666_6666, 1'b1);
    @(negedge clk);
    chk("early_frame_error", frame_error, 1);
    chk("early_no_busy", busy, 0);
    @(posedge clk);
    #1;
    send_round(32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'hFF00_0000);
    cycles(2);
    finish_round(1'b0);
    cycles(2);

    // Missing s_last: drop through the next s_last
    do_reset();
    send(32'h7777_7777, 1'b0);
    send(32'h7777_7777, 1'b0);
    send(32'h7777_7777, 1'b0);
    send(32'h7777_7777, 1'b0);
    @(negedge clk);
    chk("late_frame_error", frame_error, 1);
    @(posedge clk);
    #1;
    send(32'h8888_8888, 1'b0);
    send(32'h9999_9999, 1'b1);
    @(negedge clk);
    chk("drop_no_busy", busy, 0);
    @(posedge clk);
    #1;
    send_round(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004);
    cycles(2);

    // Deadlock completion
    finish_round(1'b1);
    @(negedge clk);
    chk("deadlock_busy_fall", busy, 0);
    @(posedge clk);
    #1;

    // Reset mid-WAIT with a pending bank
    send_round(32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404);
    cycles(2);
    send(32'hF0F0_F0F0, 1'b0);
    send(32'hF0F0_F0F0, 1'b0);
    send(32'hF0F0_F0F0, 1'b0);
    send(32'hF0F0_F0F0, 1'b1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_syndromes", is_error_syndromes, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_round_id", round_id, 0);
    chk("mid_rst_frame_error", frame_error, 0);
    chk("mid_rst_done", round_done, 0);
    cycles(4);
    @(negedge clk);
    chk("pending_dropped", busy, 0);
    @(posedge clk);
    #1;
    send_round(32'h1357_9BDF, 32'h2468_ACE0, 32'hFEDC_BA98, 32'h7654_3210);
    cycles(2);
    finish_round(1'b0);
    cycles(3);

    chk("start_queue_empty", exp_vec_q.size(), 0);
    chk("done_queue_empty", exp_abort_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
